// File: rtl/mode_scheduler_if.sv
// mode_scheduler_if
//   Bundles the mode/LCD/switch signals that pass between the digital-clock
//   mode blocks, lcd_driver and mode_scheduler.
//   master : the environment (drives requests, switches, LCD index, mode chars)
//   slave  : mode_scheduler (drives data_char, data_sw*, mode_cur, switching, ring)
interface mode_scheduler_if;
    logic       en_1hz;
    logic [1:0] dip_sw;
    logic [3:0] sw_in;
    logic [4:0] index_char;
    logic [7:0] data_mode0;
    logic [7:0] data_mode1;
    logic [7:0] data_mode2;
    logic       alarm_hit;
    logic [7:0] data_char;
    logic [3:0] data_sw0;
    logic [3:0] data_sw1;
    logic [3:0] data_sw2;
    logic [1:0] mode_cur;
    logic       switching;
    logic       ring;

    modport master (
        output en_1hz, dip_sw, sw_in, index_char,
        output data_mode0, data_mode1, data_mode2, alarm_hit,
        input  data_char, data_sw0, data_sw1, data_sw2,
        input  mode_cur, switching, ring
    );

    modport slave (
        input  en_1hz, dip_sw, sw_in, index_char,
        input  data_mode0, data_mode1, data_mode2, alarm_hit,
        output data_char, data_sw0, data_sw1, data_sw2,
        output mode_cur, switching, ring
    );
endinterface

// File: rtl/mode_scheduler.sv
// mode_scheduler
//   Owns the shared LCD character path and the debounced switch bus of the
//   digital clock. One mode (watch 00, set 01, alarm 10) owns the LCD at a
//   time; ownership changes only at an LCD frame wrap (index_char FRAME_LAST->0),
//   and keys held across a handover are blocked until all switches are released.
//   An alarm_hit in watch mode rings for RING_S seconds or until a key press.
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous reset, active-low
//     bus  : mode_scheduler_if.slave (requests, switches, LCD index/chars, outputs)
//
//   Build option
//     MODE_SCHED_TIMEOUT_EN : when defined, set/alarm mode falls back to watch
//     after TIMEOUT_S seconds without a key press. Undefined: modes held forever.
module mode_scheduler #(
    parameter int TIMEOUT_S  = 30,
    parameter int RING_S     = 10,
    parameter int FRAME_LAST = 31
) (
    input logic             clk,
    input logic             rst,
    mode_scheduler_if.slave bus
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_ALERT  = 2'd2;

    // Seconds-counter width sized for the longer of the two timed intervals.
    localparam int SEC_MAX = (TIMEOUT_S > RING_S) ? TIMEOUT_S : RING_S;
    localparam int RING_W  = $clog2(SEC_MAX + 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              sw_lock_q, sw_lock_d;
    logic              switching_q, switching_d;
    logic              ring_q, ring_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [3:0]        sw0_q, sw0_d;
    logic [3:0]        sw1_q, sw1_d;
    logic [3:0]        sw2_q, sw2_d;
    logic [4:0]        idx_prev_q;
    logic [3:0]        sw_prev_q;
    logic [1:0]        dip_q;

    logic [3:0]        press;
    logic              boundary;
    logic [1:0]        dip_map;
    logic [1:0]        req;

    assign press    = bus.sw_in & ~sw_prev_q;
    assign boundary = (bus.index_char == 5'd0) && (idx_prev_q == 5'(FRAME_LAST));
    assign dip_map  = (dip_q == 2'b11) ? 2'b00 : dip_q;

`ifdef MODE_SCHED_TIMEOUT_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       forced_q, forced_d;

    // A forced return pins the request to watch until the DIP switch moves.
    assign req = forced_q ? 2'b00 : dip_map;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        forced_d   = forced_q;
        if ((state_q == ST_ACTIVE) && (mode_q != 2'b00)) begin
            if (|press) begin
                idle_cnt_d = 8'd0;
            end else if (bus.en_1hz && (idle_cnt_q != 8'hFF)) begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
            if (idle_cnt_q >= 8'(TIMEOUT_S)) begin
                forced_d = 1'b1;
            end
        end else begin
            idle_cnt_d = 8'd0;
        end
        if (bus.dip_sw != dip_q) begin
            forced_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= 8'd0;
            forced_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            forced_q   <= forced_d;
        end
    end
`else
    assign req = dip_map;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sw_lock_d   = sw_lock_q;
        switching_d = switching_q;
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;
        sw0_d       = 4'd0;
        sw1_d       = 4'd0;
        sw2_d       = 4'd0;

        // Release clears the lock; any set below overrides it in the same cycle.
        if (bus.sw_in == 4'd0) begin
            sw_lock_d = 1'b0;
        end

        case (state_q)
            ST_ACTIVE: begin
                if (!sw_lock_q) begin
                    case (mode_q)
                        2'b00:   sw0_d = bus.sw_in;
                        2'b01:   sw1_d = bus.sw_in;
                        2'b10:   sw2_d = bus.sw_in;
                        default: ;
                    endcase
                end
                // Alarm takes priority over a pending request; the request is
                // picked up again once the ring ends.
                if ((mode_q == 2'b00) && bus.alarm_hit) begin
                    state_d    = ST_ALERT;
                    ring_d     = 1'b1;
                    ring_cnt_d = '0;
                end else if (req != mode_q) begin
                    state_d     = ST_DRAIN;
                    switching_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (req == mode_q) begin
                    state_d     = ST_ACTIVE;
                    switching_d = 1'b0;
                end else if (boundary) begin
                    state_d     = ST_ACTIVE;
                    mode_d      = req;
                    sw_lock_d   = 1'b1;
                    switching_d = 1'b0;
                end
            end
            ST_ALERT: begin
                // A press only acknowledges the ring; it is locked out of watch mode.
                if (|press) begin
                    state_d   = ST_ACTIVE;
                    ring_d    = 1'b0;
                    sw_lock_d = 1'b1;
                end else if (bus.en_1hz) begin
                    if (ring_cnt_q == RING_W'(RING_S - 1)) begin
                        state_d = ST_ACTIVE;
                        ring_d  = 1'b0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RING_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACTIVE;
            mode_q      <= 2'b00;
            sw_lock_q   <= 1'b0;
            switching_q <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
            sw0_q       <= 4'd0;
            sw1_q       <= 4'd0;
            sw2_q       <= 4'd0;
            idx_prev_q  <= 5'd0;
            sw_prev_q   <= 4'd0;
            dip_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sw_lock_q   <= sw_lock_d;
            switching_q <= switching_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            sw0_q       <= sw0_d;
            sw1_q       <= sw1_d;
            sw2_q       <= sw2_d;
            idx_prev_q  <= bus.index_char;
            sw_prev_q   <= bus.sw_in;
            dip_q       <= bus.dip_sw;
        end
    end

    always_comb begin
        case (mode_q)
            2'b01:   bus.data_char = bus.data_mode1;
            2'b10:   bus.data_char = bus.data_mode2;
            default: bus.data_char = bus.data_mode0;
        endcase
    end

    assign bus.data_sw0  = sw0_q;
    assign bus.data_sw1  = sw1_q;
    assign bus.data_sw2  = sw2_q;
    assign bus.mode_cur  = mode_q;
    assign bus.switching = switching_q;
    assign bus.ring      = ring_q;

endmodule

// File: tb/tb_mode_scheduler.sv
module tb_mode_scheduler;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mode_scheduler_if bus ();

    mode_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dip;
        logic [3:0] sw;
        logic [4:0] idx;
        logic [1:0] e_mode;
        logic       e_swi;
        logic [7:0] e_ch;
        logic [3:0] e_s0;
        logic [3:0] e_s1;
        logic [3:0] e_s2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] dip, input logic [3:0] sw, input logic [4:0] idx,
                                input logic [1:0] e_mode, input logic e_swi, input logic [7:0] e_ch,
                                input logic [3:0] e_s0, input logic [3:0] e_s1, input logic [3:0] e_s2);
        vec_t v;
        v.dip = dip; v.sw = sw; v.idx = idx;
        v.e_mode = e_mode; v.e_swi = e_swi; v.e_ch = e_ch;
        v.e_s0 = e_s0; v.e_s1 = e_s1; v.e_s2 = e_s2;
        return v;
    endfunction

    // {mode_cur, switching, ring, data_char, data_sw0, data_sw1, data_sw2}
    function automatic logic [23:0] snap();
        return {bus.mode_cur, bus.switching, bus.ring, bus.data_char,
                bus.data_sw0, bus.data_sw1, bus.data_sw2};
    endfunction

    localparam logic [23:0] RESET_SNAP = {2'b00, 1'b0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrap();
        bus.index_char = 5'd31;
        tick();
        bus.index_char = 5'd0;
        tick();
        bus.index_char = 5'd1;
    endtask

    task automatic pulse();
        bus.en_1hz = 1'b1;
        tick();
        bus.en_1hz = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.en_1hz = 1'b0;
        bus.dip_sw = 2'b01;
        bus.sw_in = 4'h0;
        bus.index_char = 5'd5;
        bus.data_mode0 = 8'h30;
        bus.data_mode1 = 8'h31;
        bus.data_mode2 = 8'h32;
        bus.alarm_hit = 1'b0;

        //           dip   sw    idx    mode  swi  char   s0    s1    s2
        vecs.push_back(mk(2'd1, 4'h0, 5'd5,  2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h0, 5'd6,  2'd0, 1'b1, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h0, 5'd31, 2'd0, 1'b1, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h0, 5'd0,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd1,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd31, 2'd1, 1'b1, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd0,  2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd1,  2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h4, 5'd2,  2'd0, 1'b0, 8'h30, 4'h4, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h4, 5'd31, 2'd0, 1'b1, 8'h30, 4'h4, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h4, 5'd0,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h4, 5'd1,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h0, 5'd2,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd1, 4'h4, 5'd3,  2'd1, 1'b0, 8'h31, 4'h0, 4'h4, 4'h0));
        vecs.push_back(mk(2'd1, 4'h0, 5'd4,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd5,  2'd1, 1'b0, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd6,  2'd1, 1'b1, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd31, 2'd1, 1'b1, 8'h31, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd0,  2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd12, 2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd12, 2'd0, 1'b1, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd13, 2'd0, 1'b1, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd31, 2'd0, 1'b1, 8'h30, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd0,  2'd2, 1'b0, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd3, 4'h0, 5'd1,  2'd2, 1'b0, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd3, 4'h0, 5'd2,  2'd2, 1'b1, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd31, 2'd2, 1'b1, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd2, 4'h0, 5'd0,  2'd2, 1'b0, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd1,  2'd2, 1'b0, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd2,  2'd2, 1'b1, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd0,  2'd2, 1'b1, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd31, 2'd2, 1'b1, 8'h32, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(2'd0, 4'h0, 5'd0,  2'd0, 1'b0, 8'h30, 4'h0, 4'h0, 4'h0));

        // Reset held with a set-mode request pending
        repeat (2) tick();
        chk("reset_state", {8'h0, snap()}, {8'h0, RESET_SNAP});
        rst = 1'b1;

        // Handover table
        for (int i = 0; i < vecs.size(); i++) begin
            bus.dip_sw     = vecs[i].dip;
            bus.sw_in      = vecs[i].sw;
            bus.index_char = vecs[i].idx;
            tick();
            chk($sformatf("row%0d", i), {8'h0, snap()},
                {8'h0, vecs[i].e_mode, vecs[i].e_swi, 1'b0, vecs[i].e_ch,
                 vecs[i].e_s0, vecs[i].e_s1, vecs[i].e_s2});
        end

        // Alarm ring for RING_S seconds
        bus.index_char = 5'd1;
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("ring_on", {31'h0, bus.ring}, 32'h1);
        chk("ring_char", {24'h0, bus.data_char}, 32'h30);
        repeat (9) pulse();
        chk("ring_after9", {31'h0, bus.ring}, 32'h1);
        bus.en_1hz = 1'b1;
        tick();
        bus.en_1hz = 1'b0;
        chk("ring_after10", {31'h0, bus.ring}, 32'h0);

        // Ring acknowledged by a press on the third pulse
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("ring2_on", {31'h0, bus.ring}, 32'h1);
        repeat (2) pulse();
        bus.en_1hz = 1'b1;
        bus.sw_in = 4'h1;
        tick();
        bus.en_1hz = 1'b0;
        chk("ack_ring", {31'h0, bus.ring}, 32'h0);
        chk("ack_sw0", {28'h0, bus.data_sw0}, 32'h0);
        tick();
        chk("ack_held", {28'h0, bus.data_sw0}, 32'h0);
        bus.sw_in = 4'h0;
        tick();
        bus.sw_in = 4'h1;
        tick();
        chk("press_after_ack", {28'h0, bus.data_sw0}, 32'h1);
        bus.sw_in = 4'h0;
        tick();

        // Alarm and request change together: alarm wins, request served after
        bus.dip_sw = 2'b01;
        tick();
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("both_ring", {31'h0, bus.ring}, 32'h1);
        chk("both_noswitch", {31'h0, bus.switching}, 32'h0);
        bus.sw_in = 4'h2;
        tick();
        chk("both_ack", {31'h0, bus.ring}, 32'h0);
        bus.sw_in = 4'h0;
        tick();
        chk("both_drain", {31'h0, bus.switching}, 32'h1);
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("alarm_in_drain", {31'h0, bus.ring}, 32'h0);
        wrap();
        chk("both_mode1", {30'h0, bus.mode_cur}, 32'h1);
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("alarm_in_set", {31'h0, bus.ring}, 32'h0);

        // Inactivity in set mode
`ifdef MODE_SCHED_TIMEOUT_EN
        repeat (29) pulse();
        chk("idle29", {31'h0, bus.switching}, 32'h0);
        pulse();
        tick();
        chk("idle_drain", {29'h0, bus.switching, bus.mode_cur}, {29'h0, 1'b1, 2'b01});
        wrap();
        chk("idle_watch", {30'h0, bus.mode_cur}, 32'h0);
        tick();
        tick();
        chk("forced_hold", {29'h0, bus.switching, bus.mode_cur}, 32'h0);
        bus.dip_sw = 2'b00;
        tick();
        bus.dip_sw = 2'b01;
        tick();
        tick();
        chk("reselect_drain", {31'h0, bus.switching}, 32'h1);
        wrap();
        chk("reselect_set", {30'h0, bus.mode_cur}, 32'h1);
`else
        repeat (35) pulse();
        tick();
        chk("no_timeout", {29'h0, bus.switching, bus.mode_cur}, {29'h0, 1'b0, 2'b01});
`endif

        // Asynchronous reset during DRAIN
        bus.dip_sw = 2'b00;
        tick();
        tick();
        chk("pre_rst_drain", {31'h0, bus.switching}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_drain", {8'h0, snap()}, {8'h0, RESET_SNAP});
        tick();
        rst = 1'b1;

        // Asynchronous reset during ALERT
        bus.alarm_hit = 1'b1;
        tick();
        bus.alarm_hit = 1'b0;
        chk("pre_rst_alert", {31'h0, bus.ring}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_alert", {8'h0, snap()}, {8'h0, RESET_SNAP});
        tick();
        rst = 1'b1;
        tick();
        chk("after_rst", {8'h0, snap()}, {8'h0, RESET_SNAP});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
